// File: rtl/riscv_alu_ctrl_decoder.sv
// RV32I decode stage: instruction word -> ALUControl, operand selects and branch polarity.
// Registered output with a one-entry skid buffer so in_ready never depends on out_ready.
module riscv_alu_ctrl_decoder #(
  parameter int unsigned XLEN = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [XLEN-1:0] in_instr,
  input  logic [XLEN-1:0] in_pc,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [3:0]      out_alu_ctrl,
  output logic [1:0]      out_src_a,
  output logic            out_src_b_imm,
  output logic            out_is_branch,
  output logic            out_br_take_on_z,
  output logic            out_illegal,
  output logic [XLEN-1:0] out_pc,
  output logic [XLEN-1:0] out_instr
);

  typedef enum logic [3:0] {
    ALU_ADD  = 4'd0,
    ALU_SUB  = 4'd1,
    ALU_OR   = 4'd2,
    ALU_AND  = 4'd3,
    ALU_XOR  = 4'd4,
    ALU_SLL  = 4'd5,
    ALU_SRL  = 4'd6,
    ALU_SRA  = 4'd7,
    ALU_SLT  = 4'd8,
    ALU_SLTU = 4'd9
  } alu_e;

  typedef enum logic [1:0] {
    SRC_RS1  = 2'd0,
    SRC_PC   = 2'd1,
    SRC_ZERO = 2'd2
  } src_a_e;

  typedef enum logic [6:0] {
    OPC_OP     = 7'b0110011,
    OPC_OP_IMM = 7'b0010011,
    OPC_LOAD   = 7'b0000011,
    OPC_STORE  = 7'b0100011,
    OPC_LUI    = 7'b0110111,
    OPC_AUIPC  = 7'b0010111,
    OPC_JAL    = 7'b1101111,
    OPC_JALR   = 7'b1100111,
    OPC_BRANCH = 7'b1100011
  } opcode_e;

  typedef struct packed {
    alu_e            alu;
    src_a_e          src_a;
    logic            src_b_imm;
    logic            is_branch;
    logic            take_on_z;
    logic            illegal;
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] instr;
  } entry_t;

  entry_t     dec;
  entry_t     out_q;
  entry_t     skid_q;
  logic       out_valid_q;
  logic       skid_valid_q;
  alu_e       base_alu;
  logic [2:0] funct3;
  logic [6:0] funct7;

  assign funct3 = in_instr[14:12];
  assign funct7 = in_instr[31:25];

  // Shared funct3 mapping for OP and OP-IMM; funct7 qualification happens below.
  always_comb begin
    base_alu = ALU_ADD;
    unique case (funct3)
      3'b000:  base_alu = ALU_ADD;
      3'b001:  base_alu = ALU_SLL;
      3'b010:  base_alu = ALU_SLT;
      3'b011:  base_alu = ALU_SLTU;
      3'b100:  base_alu = ALU_XOR;
      3'b101:  base_alu = ALU_SRL;
      3'b110:  base_alu = ALU_OR;
      default: base_alu = ALU_AND;
    endcase
  end

  always_comb begin
    dec       = '0;
    dec.pc    = in_pc;
    dec.instr = in_instr;
    case (in_instr[6:0])
      OPC_OP: begin
        if (funct7 == 7'b0000000)
          dec.alu = base_alu;
        else if (funct7 == 7'b0100000 && funct3 == 3'b000)
          dec.alu = ALU_SUB;
        else if (funct7 == 7'b0100000 && funct3 == 3'b101)
          dec.alu = ALU_SRA;
        else
          dec.illegal = 1'b1;
      end
      OPC_OP_IMM: begin
        dec.src_b_imm = 1'b1;
        dec.alu       = base_alu;
        if (funct3 == 3'b001 && funct7 != 7'b0000000)
          dec.illegal = 1'b1;
        else if (funct3 == 3'b101) begin
          if (funct7 == 7'b0100000)
            dec.alu = ALU_SRA;
          else if (funct7 != 7'b0000000)
            dec.illegal = 1'b1;
        end
      end
      OPC_LOAD, OPC_STORE: dec.src_b_imm = 1'b1;
      OPC_LUI: begin
        dec.src_a     = SRC_ZERO;
        dec.src_b_imm = 1'b1;
      end
      OPC_AUIPC, OPC_JAL: begin
        dec.src_a     = SRC_PC;
        dec.src_b_imm = 1'b1;
      end
      OPC_JALR: dec.src_b_imm = 1'b1;
      OPC_BRANCH: begin
        dec.is_branch = 1'b1;
        case (funct3)
          3'b000: begin dec.alu = ALU_SUB;  dec.take_on_z = 1'b1; end
          3'b001: begin dec.alu = ALU_SUB;  dec.take_on_z = 1'b0; end
          3'b100: begin dec.alu = ALU_SLT;  dec.take_on_z = 1'b0; end
          3'b101: begin dec.alu = ALU_SLT;  dec.take_on_z = 1'b1; end
          3'b110: begin dec.alu = ALU_SLTU; dec.take_on_z = 1'b0; end
          3'b111: begin dec.alu = ALU_SLTU; dec.take_on_z = 1'b1; end
          default: dec.illegal = 1'b1;
        endcase
      end
      default: dec.illegal = 1'b1;
    endcase
    // Illegal encodings carry no control, only the pass-through fields.
    if (dec.illegal) begin
      dec.alu       = ALU_ADD;
      dec.src_a     = SRC_RS1;
      dec.src_b_imm = 1'b0;
      dec.is_branch = 1'b0;
      dec.take_on_z = 1'b0;
    end
  end

  logic in_xfer;
  logic out_free;

  assign in_ready = ~skid_valid_q;
  assign in_xfer  = in_valid & in_ready;
  assign out_free = ~out_valid_q | out_ready;

  // While the skid is full in_ready is low, so the skid and a new input never compete.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_q        <= '0;
      skid_q       <= '0;
      out_valid_q  <= 1'b0;
      skid_valid_q <= 1'b0;
    end else if (flush) begin
      out_valid_q  <= 1'b0;
      skid_valid_q <= 1'b0;
    end else if (out_free) begin
      if (skid_valid_q) begin
        out_q        <= skid_q;
        out_valid_q  <= 1'b1;
        skid_valid_q <= 1'b0;
      end else if (in_xfer) begin
        out_q       <= dec;
        out_valid_q <= 1'b1;
      end else begin
        out_valid_q <= 1'b0;
      end
    end else if (in_xfer) begin
      skid_q       <= dec;
      skid_valid_q <= 1'b1;
    end
  end

  assign out_valid        = out_valid_q;
  assign out_alu_ctrl     = out_q.alu;
  assign out_src_a        = out_q.src_a;
  assign out_src_b_imm    = out_q.src_b_imm;
  assign out_is_branch    = out_q.is_branch;
  assign out_br_take_on_z = out_q.take_on_z;
  assign out_illegal      = out_q.illegal;
  assign out_pc           = out_q.pc;
  assign out_instr        = out_q.instr;

endmodule

// File: tb/tb_riscv_alu_ctrl_decoder.sv
// Scoreboard bench for riscv_alu_ctrl_decoder: expected decodes are queued on input
// transfer and checked by an independent monitor on each output transfer.
module tb_riscv_alu_ctrl_decoder;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        flush;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_instr;
  logic [31:0] in_pc;
  logic        out_valid;
  logic        out_ready;
  logic [3:0]  out_alu_ctrl;
  logic [1:0]  out_src_a;
  logic        out_src_b_imm;
  logic        out_is_branch;
  logic        out_br_take_on_z;
  logic        out_illegal;
  logic [31:0] out_pc;
  logic [31:0] out_instr;

  always #5 clk = ~clk;

  riscv_alu_ctrl_decoder #(.XLEN(32)) dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .flush            (flush),
    .in_valid         (in_valid),
    .in_ready         (in_ready),
    .in_instr         (in_instr),
    .in_pc            (in_pc),
    .out_valid        (out_valid),
    .out_ready        (out_ready),
    .out_alu_ctrl     (out_alu_ctrl),
    .out_src_a        (out_src_a),
    .out_src_b_imm    (out_src_b_imm),
    .out_is_branch    (out_is_branch),
    .out_br_take_on_z (out_br_take_on_z),
    .out_illegal      (out_illegal),
    .out_pc           (out_pc),
    .out_instr        (out_instr)
  );

  typedef struct packed {
    logic [3:0]  alu;
    logic [1:0]  src_a;
    logic        imm;
    logic        br;
    logic        z;
    logic        ill;
    logic [31:0] pc;
    logic [31:0] instr;
  } exp_t;

  exp_t q[$];
  int   acc_q[$];
  int   hits[$];
  int   cyc = 0;
  int   compared = 0;
  int   mismatched = 0;
  bit   chk_lat = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
    compared++;
    if (got !== want) begin
      mismatched++;
      $display("FAIL %s: got %h expected %h", name, got, want);
    end
  endtask

  // Monitor: every out_valid & out_ready cycle is one delivered entry.
  initial begin : monitor
    exp_t e;
    exp_t a;
    int   acc;
    forever begin
      @(negedge clk);
      if (rst_n && out_valid && out_ready) begin
        a = {out_alu_ctrl, out_src_a, out_src_b_imm, out_is_branch, out_br_take_on_z,
             out_illegal, out_pc, out_instr};
        if (q.size() == 0) begin
          compared++;
          mismatched++;
          $display("FAIL unexpected_output: got instr %h pc %h, expected none", out_instr, out_pc);
        end else begin
          e   = q.pop_front();
          acc = acc_q.pop_front();
          compared++;
          if (a !== e) begin
            mismatched++;
            $display("FAIL decode %h: got ctrl=%h srca=%0d imm=%b br=%b z=%b ill=%b pc=%h instr=%h expected ctrl=%h srca=%0d imm=%b br=%b z=%b ill=%b pc=%h instr=%h",
                     e.instr, a.alu, a.src_a, a.imm, a.br, a.z, a.ill, a.pc, a.instr,
                     e.alu, e.src_a, e.imm, e.br, e.z, e.ill, e.pc, e.instr);
          end
          if (chk_lat) begin
            compared++;
            if (cyc != acc + 1) begin
              mismatched++;
              $display("FAIL latency %h: got %0d cycles expected 1", e.instr, cyc - acc);
            end
          end
          hits.push_back(cyc);
        end
      end
    end
  end

  // Called just after a rising edge; returns just after the edge that transfers.
  task automatic send(input logic [31:0] ins, input logic [31:0] pc, input logic [3:0] alu,
                      input logic [1:0] sa, input logic imm, input logic br, input logic z,
                      input logic ill);
    int n;
    in_instr = ins;
    in_pc    = pc;
    in_valid = 1'b1;
    n = 0;
    @(negedge clk);
    while (!in_ready && n < 50) begin
      n++;
      @(negedge clk);
    end
    if (!in_ready) begin
      compared++;
      mismatched++;
      $display("FAIL accept_timeout %h: got in_ready 0 expected 1", ins);
    end else begin
      q.push_back({alu, sa, imm, br, z, ill, pc, ins});
      acc_q.push_back(cyc);
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (q.size() != 0 && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk("drain_left", q.size(), 0);
    @(posedge clk);
    #1;
  endtask

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: got no finish expected finish");
    $fatal(1, "watchdog");
  end

  initial begin : stim
    int d;
    rst_n     = 1'b0;
    flush     = 1'b0;
    in_valid  = 1'b0;
    in_instr  = '0;
    in_pc     = '0;
    out_ready = 1'b1;
    #13;
    chk("rst_out_valid", {31'b0, out_valid}, 0);
    chk("rst_in_ready", {31'b0, in_ready}, 1);
    chk("rst_alu_ctrl", {28'b0, out_alu_ctrl}, 0);
    chk("rst_pc", out_pc, 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    chk_lat = 1'b1;
    send(32'h002081B3, 32'h0000_0100, 4'd0, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0); // add
    drain();

    send(32'h402081B3, 32'h0000_0104, 4'd1, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0); // sub
    send(32'h40335293, 32'h0000_0108, 4'd7, 2'd0, 1'b1, 1'b0, 1'b0, 1'b0); // srai
    drain();
    d = hits[hits.size()-1] - hits[hits.size()-2];
    chk("back_to_back_gap", d, 1);

    send(32'h0020C063, 32'h0000_0200, 4'd8, 2'd0, 1'b0, 1'b1, 1'b0, 1'b0); // blt
    send(32'h00208063, 32'h0000_0204, 4'd1, 2'd0, 1'b0, 1'b1, 1'b1, 1'b0); // beq
    send(32'h00209063, 32'h0000_0208, 4'd1, 2'd0, 1'b0, 1'b1, 1'b0, 1'b0); // bne
    send(32'h0020F063, 32'h0000_020C, 4'd9, 2'd0, 1'b0, 1'b1, 1'b1, 1'b0); // bgeu
    send(32'h0020A063, 32'h0000_0210, 4'd0, 2'd0, 1'b0, 1'b0, 1'b0, 1'b1); // branch f3=010
    send(32'h022081B3, 32'h0000_0214, 4'd0, 2'd0, 1'b0, 1'b0, 1'b0, 1'b1); // mul
    send(32'h0000007F, 32'hDEAD_BEEC, 4'd0, 2'd0, 1'b0, 1'b0, 1'b0, 1'b1); // bad opcode
    send(32'h40209093, 32'h0000_021C, 4'd0, 2'd0, 1'b0, 1'b0, 1'b0, 1'b1); // slli bad imm
    send(32'h123450B7, 32'h0000_0220, 4'd0, 2'd2, 1'b1, 1'b0, 1'b0, 1'b0); // lui
    send(32'h00001097, 32'h0000_0224, 4'd0, 2'd1, 1'b1, 1'b0, 1'b0, 1'b0); // auipc
    send(32'h008000EF, 32'h0000_0228, 4'd0, 2'd1, 1'b1, 1'b0, 1'b0, 1'b0); // jal
    send(32'h000080E7, 32'h0000_022C, 4'd0, 2'd0, 1'b1, 1'b0, 1'b0, 1'b0); // jalr
    send(32'h0000A083, 32'h0000_0230, 4'd0, 2'd0, 1'b1, 1'b0, 1'b0, 1'b0); // lw
    send(32'h0010A023, 32'h0000_0234, 4'd0, 2'd0, 1'b1, 1'b0, 1'b0, 1'b0); // sw
    send(32'hFFF0F093, 32'h0000_0238, 4'd3, 2'd0, 1'b1, 1'b0, 1'b0, 1'b0); // andi -1
    send(32'h0020D0B3, 32'h0000_023C, 4'd6, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0); // srl
    send(32'h0020B0B3, 32'h0000_0240, 4'd9, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0); // sltu
    send(32'h0020C0B3, 32'h0000_0244, 4'd4, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0); // xor
    send(32'h002090B3, 32'h0000_0248, 4'd5, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0); // sll
    send(32'h0020E0B3, 32'h0000_024C, 4'd2, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0); // or
    drain();

    // Stall: first entry held, second in the skid, third waits on in_ready.
    chk_lat   = 1'b0;
    out_ready = 1'b0;
    send(32'h002081B3, 32'h0000_0300, 4'd0, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    send(32'h402081B3, 32'h0000_0304, 4'd1, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    chk("stall_in_ready", {31'b0, in_ready}, 0);
    chk("stall_held_instr", out_instr, 32'h002081B3);
    fork
      send(32'h40335293, 32'h0000_0308, 4'd7, 2'd0, 1'b1, 1'b0, 1'b0, 1'b0);
      begin
        @(posedge clk);
        @(negedge clk);
        chk("stall_stable_pc", out_pc, 32'h0000_0300);
        @(posedge clk);
        #1;
        out_ready = 1'b1;
      end
    join
    drain();
    chk("stall_in_ready_back", {31'b0, in_ready}, 1);

    // Flush with skid full and a new input presented.
    out_ready = 1'b0;
    send(32'h0020C063, 32'h0000_0400, 4'd8, 2'd0, 1'b0, 1'b1, 1'b0, 1'b0);
    send(32'h00208063, 32'h0000_0404, 4'd1, 2'd0, 1'b0, 1'b1, 1'b1, 1'b0);
    flush    = 1'b1;
    in_valid = 1'b1;
    in_instr = 32'h0020E0B3;
    @(posedge clk);
    #1;
    flush    = 1'b0;
    in_valid = 1'b0;
    q.delete();
    acc_q.delete();
    @(negedge clk);
    chk("flush_out_valid", {31'b0, out_valid}, 0);
    chk("flush_in_ready", {31'b0, in_ready}, 1);
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    send(32'h0020B0B3, 32'h0000_0500, 4'd9, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    drain();
    repeat (3) @(posedge clk);
    #1;

    // Asynchronous reset in the middle of a stall.
    out_ready = 1'b0;
    send(32'h002090B3, 32'h0000_0600, 4'd5, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    send(32'h0020D0B3, 32'h0000_0604, 4'd6, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    #2;
    rst_n = 1'b0;
    #1;
    chk("midrst_out_valid", {31'b0, out_valid}, 0);
    chk("midrst_in_ready", {31'b0, in_ready}, 1);
    q.delete();
    acc_q.delete();
    @(negedge clk);
    rst_n     = 1'b1;
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    send(32'h0020C0B3, 32'h0000_0700, 4'd4, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    drain();
    repeat (2) @(posedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/riscv_alu_ctrl_decoder.md
Name: riscv_alu_ctrl_decoder

Overview:
- Decode stage that turns RV32I instruction words into the 4-bit ALUControl code, operand selects and branch-flag polarity consumed by RISCV_ALU.
- Registered output with a valid/ready handshake on both sides and a one-entry skid buffer, so it can stall against the execute stage without a combinational ready path.
- Latency is 1 cycle. Sits between instruction fetch and the ALU/execute stage.

Parameters:
- XLEN, 32, instruction and PC width; only 32 is supported.

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- flush  in  1  synchronous pipeline flush; drops all held entries
- in_valid  in  1  instruction/PC pair presented
- in_ready  out  1  decoder can accept this cycle
- in_instr  in  32  instruction word
- in_pc  in  32  PC of instruction
- out_valid  out  1  decoded entry presented
- out_ready  in  1  execute stage accepts this cycle
- out_alu_ctrl  out  4  ALUControl code: 0 ADD, 1 SUB, 2 OR, 3 AND, 4 XOR, 5 SLL, 6 SRL, 7 SRA, 8 SLT, 9 SLTU
- out_src_a  out  2  ALU A select: 0 rs1, 1 PC, 2 zero
- out_src_b_imm  out  1  1 = B is immediate, 0 = rs2
- out_is_branch  out  1  conditional branch
- out_br_take_on_z  out  1  branch taken when Z=1 (else taken when Z=0)
- out_illegal  out  1  unsupported encoding
- out_pc  out  32  PC passed through
- out_instr  out  32  instruction passed through

Behaviour:
- Reset (rst_n low, asynchronous):
  - out_valid=0, in_ready=1, skid empty.
  - All other outputs 0.
- Decode:
  - OP 0110011: funct3 000 → ADD if funct7=0000000, SUB if 0100000.
  - OP 0110011: 001 → SLL; 010 → SLT; 011 → SLTU; 100 → XOR; 101 → SRL (funct7 0000000) or SRA (0100000); 110 → OR; 111 → AND.
  - OP 0110011: any other funct7 is illegal.
  - OP-IMM 0010011: same mapping with src_b_imm=1; ADDI and the non-shift codes ignore funct7.
  - OP-IMM shifts: funct3 001 needs imm[11:5]=0000000; funct3 101 needs 0000000 (SRL) or 0100000 (SRA); otherwise illegal.
  - LOAD 0000011 and STORE 0100011 → ADD, src_b_imm=1.
  - LUI 0110111 → ADD, src_a=zero, imm=1. AUIPC 0010111 → ADD, src_a=PC, imm=1.
  - JAL 1101111 → ADD, src_a=PC, imm=1. JALR 1100111 → ADD, src_a=rs1, imm=1.
  - BRANCH 1100011, is_branch=1:
    - BEQ → SUB, take_on_z=1.
    - BNE → SUB, take_on_z=0.
    - BLT → SLT, take_on_z=0.
    - BGE → SLT, take_on_z=1.
    - BLTU → SLTU, take_on_z=0.
    - BGEU → SLTU, take_on_z=1.
    - funct3 010/011 illegal.
  - Any other opcode is illegal.
  - On illegal: alu_ctrl=0, src_a=0, imm=0, is_branch=0, illegal=1; pc and instr still pass through.
- Handshake:
  - Input transfer when in_valid&in_ready; output transfer when out_valid&out_ready.
  - in_ready is registered: in_ready = !skid_valid.
  - Input accepted while output is empty or being consumed: decoded entry loads into the output register the next cycle.
  - Input accepted while output is held (out_valid & !out_ready): decoded entry goes into the skid.
  - Skid is non-empty and output consumed: skid moves to the output register and in_ready returns to 1 next cycle.
  - Output register holds stable while out_valid & !out_ready.
  - Order is strict FIFO; no entry is dropped or duplicated.
- Boundaries:
  - Simultaneous accept and consume with skid empty gives back-to-back throughput of 1 per cycle.
  - in_valid while in_ready=0: no transfer; the source must hold.
  - flush has priority over every transfer: out_valid=0 and skid cleared next cycle; an input presented that cycle is discarded.
  - Reset mid-stall: all state is cleared immediately.

Test Plan:
- add x3,x1,x2 0x002081B3, out_ready=1 → out_valid 1 cycle later; alu_ctrl=0, src_a=0, imm=0, illegal=0.
- sub 0x402081B3 then srai x5,x6,3 0x40335293 back-to-back → alu_ctrl 1 then 7 (imm=1) on consecutive cycles.
- blt x1,x2,0 0x0020C063 → alu_ctrl=8, is_branch=1, take_on_z=0. beq 0x00208063 → alu_ctrl=1, take_on_z=1.
- 0x022081B3 (MUL encoding) and 0x0000007F → illegal=1, alu_ctrl=0, pc passed through.
- Stall sequence:
  - Hold out_ready=0 and send 2 instrs: the first is held, the second goes to the skid.
  - in_ready=0 the following cycle.
  - Release out_ready: both are delivered in order and in_ready=1.
- Assert flush with the skid full and in_valid=1 → out_valid=0 next cycle, in_ready=1, no stale entry emitted.
